// File: rtl/npu_ctrl_pkg.sv
// rtl/npu_ctrl_pkg.sv - shared types and 3x3 tap geometry for the window sequencer
package npu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_TAPS = 9;

  // MSB-first row-major: bit 8 is the north-west neighbour, bit 0 the south-east one
  localparam int TAP_SE = 0;
  localparam int TAP_S  = 1;
  localparam int TAP_SW = 2;
  localparam int TAP_E  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_W  = 5;
  localparam int TAP_NE = 6;
  localparam int TAP_N  = 7;
  localparam int TAP_NW = 8;

  localparam int TAP_DR [NUM_TAPS] = '{1, 1, 1, 0, 0, 0, -1, -1, -1};
  localparam int TAP_DC [NUM_TAPS] = '{1, 0, -1, 1, 0, -1, 1, 0, -1};

endpackage

// File: rtl/window_tap_gen.sv
// rtl/window_tap_gen.sv - combinational 3x3 tap mask and address generator
module window_tap_gen
  import npu_ctrl_pkg::*;
#(
  parameter int W_B    = 7,
  parameter int H_B    = 7,
  parameter int ADDR_W = 16
) (
  input  logic [H_B-1:0]             r_i,
  input  logic [W_B-1:0]             c_i,
  input  logic [W_B-1:0]             cfg_w_i,
  input  logic [H_B-1:0]             cfg_h_i,
  input  logic [ADDR_W-1:0]          row_base_i,
  input  logic [ADDR_W-1:0]          plane_base_i,
  output logic [NUM_TAPS-1:0]        mask_o,
  output logic [NUM_TAPS*ADDR_W-1:0] addr_o
);

  localparam logic [H_B:0]    H_ONE = {{H_B{1'b0}}, 1'b1};
  localparam logic [W_B:0]    W_ONE = {{W_B{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              row_mid_ok, row_up_ok, row_dn_ok;
  logic              col_mid_ok, col_lf_ok, col_rt_ok;
  logic              tap_ok_r, tap_ok_c;
  logic [ADDR_W-1:0] center_addr, cfg_w_ext, tap_addr;

  assign row_mid_ok  = r_i < cfg_h_i;
  assign row_up_ok   = row_mid_ok && (r_i != '0);
  assign row_dn_ok   = ({1'b0, r_i} + H_ONE) < {1'b0, cfg_h_i};
  assign col_mid_ok  = c_i < cfg_w_i;
  assign col_lf_ok   = col_mid_ok && (c_i != '0);
  assign col_rt_ok   = ({1'b0, c_i} + W_ONE) < {1'b0, cfg_w_i};
  assign cfg_w_ext   = ADDR_W'(cfg_w_i);
  assign center_addr = plane_base_i + row_base_i + ADDR_W'(c_i);

  // Neighbour addresses are the centre address shifted by one row/column; wrap is harmless
  // because out-of-map taps are forced to zero.
  always_comb begin
    mask_o   = '0;
    addr_o   = '0;
    tap_ok_r = 1'b0;
    tap_ok_c = 1'b0;
    tap_addr = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_ok_r = (TAP_DR[k] < 0) ? row_up_ok : (TAP_DR[k] > 0) ? row_dn_ok : row_mid_ok;
      tap_ok_c = (TAP_DC[k] < 0) ? col_lf_ok : (TAP_DC[k] > 0) ? col_rt_ok : col_mid_ok;
      tap_addr = center_addr;
      if (TAP_DR[k] < 0) tap_addr = tap_addr - cfg_w_ext;
      if (TAP_DR[k] > 0) tap_addr = tap_addr + cfg_w_ext;
      if (TAP_DC[k] < 0) tap_addr = tap_addr - A_ONE;
      if (TAP_DC[k] > 0) tap_addr = tap_addr + A_ONE;
      mask_o[k] = tap_ok_r && tap_ok_c;
      addr_o[ADDR_W*k +: ADDR_W] = (tap_ok_r && tap_ok_c) ? tap_addr : '0;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - 3x3 window-fetch sequencer: FSM, loop counters, address accumulators
module conv_window_sequencer
  import npu_ctrl_pkg::*;
#(
  parameter int W_B    = 7,
  parameter int H_B    = 7,
  parameter int IC_B   = 4,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [W_B-1:0]             cfg_w,
  input  logic [H_B-1:0]             cfg_h,
  input  logic [IC_B-1:0]            cfg_ic,
  input  logic                       stall,
  output logic                       busy,
  output logic                       rd_en,
  output logic [NUM_TAPS*ADDR_W-1:0] rd_addr,
  output logic [NUM_TAPS-1:0]        en_read,
  output logic                       en_bias,
  output logic [IC_B-1:0]            ic_idx,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       done
);

  localparam logic [W_B-1:0]  W_ONE  = {{(W_B-1){1'b0}}, 1'b1};
  localparam logic [H_B-1:0]  H_ONE  = {{(H_B-1){1'b0}}, 1'b1};
  localparam logic [IC_B-1:0] IC_ONE = {{(IC_B-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [W_B-1:0]    w_q, w_d, c_q, c_d;
  logic [H_B-1:0]    h_q, h_d, r_q, r_d;
  logic [IC_B-1:0]   nic_q, nic_d, ic_q, ic_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, plane_base_q, plane_base_d;
  logic [ADDR_W-1:0] plane_size_q, plane_size_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              issue, last_c, last_r, last_ic;
  logic [NUM_TAPS-1:0] tap_mask;

  window_tap_gen #(.W_B(W_B), .H_B(H_B), .ADDR_W(ADDR_W)) u_tap_gen (
    .r_i          (r_q),
    .c_i          (c_q),
    .cfg_w_i      (w_q),
    .cfg_h_i      (h_q),
    .row_base_i   (row_base_q),
    .plane_base_i (plane_base_q),
    .mask_o       (tap_mask),
    .addr_o       (rd_addr)
  );

  assign issue   = (state_q == ST_RUN) && !stall;
  assign last_c  = c_q == (w_q - W_ONE);
  assign last_r  = r_q == (h_q - H_ONE);
  assign last_ic = ic_q == (nic_q - IC_ONE);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    nic_d        = nic_q;
    c_d          = c_q;
    r_d          = r_q;
    ic_d         = ic_q;
    row_base_d   = row_base_q;
    plane_base_d = plane_base_q;
    plane_size_d = plane_size_q;
    out_valid_d  = issue;
    out_last_d   = issue && last_c && last_r && last_ic;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_w == '0 || cfg_h == '0 || cfg_ic == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_RUN;
            w_d          = cfg_w;
            h_d          = cfg_h;
            nic_d        = cfg_ic;
            c_d          = '0;
            r_d          = '0;
            ic_d         = '0;
            row_base_d   = '0;
            plane_base_d = '0;
            plane_size_d = ADDR_W'(cfg_w) * ADDR_W'(cfg_h);
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (!last_c) begin
            c_d = c_q + W_ONE;
          end else begin
            c_d = '0;
            if (!last_r) begin
              r_d        = r_q + H_ONE;
              row_base_d = row_base_q + ADDR_W'(w_q);
            end else begin
              r_d        = '0;
              row_base_d = '0;
              if (!last_ic) begin
                ic_d         = ic_q + IC_ONE;
                plane_base_d = plane_base_q + plane_size_q;
              end else begin
                ic_d         = '0;
                plane_base_d = '0;
                state_d      = ST_FLUSH;
              end
            end
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      nic_q        <= '0;
      c_q          <= '0;
      r_q          <= '0;
      ic_q         <= '0;
      row_base_q   <= '0;
      plane_base_q <= '0;
      plane_size_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      nic_q        <= nic_d;
      c_q          <= c_d;
      r_q          <= r_d;
      ic_q         <= ic_d;
      row_base_q   <= row_base_d;
      plane_base_q <= plane_base_d;
      plane_size_q <= plane_size_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign rd_en     = issue;
  assign en_read   = issue ? tap_mask : '0;
  assign en_bias   = issue && (ic_q == '0);
  assign ic_idx    = ic_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_FLUSH) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequencer that drives the 3x3 window-fetch datapath of the NPU's PE feed stage. For every output pixel of a feature map it issues one cycle carrying nine tap read addresses, the 9-bit per-tap enable mask `en_read` (0 = zero-pad tap) and the `en_bias` flag. The mask and `en_bias` feed the fmap/bias gating stage, which registers them one cycle. The block iterates over input-channel planes, row and column, and stalls under downstream back-pressure.

## Interface
- `W_B`, 7: bit width of `cfg_w` and the column counter.
- `H_B`, 7: bit width of `cfg_h` and the row counter.
- `IC_B`, 4: bit width of `cfg_ic` and `ic_idx`.
- `ADDR_W`, 16: width of one fmap memory address.
- `clk`  in  1  clock. One clock domain; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch pulse. Sampled only in IDLE.
- `cfg_w`  in  W_B  fmap width in pixels. Captured at `start`.
- `cfg_h`  in  H_B  fmap height in pixels. Captured at `start`.
- `cfg_ic`  in  IC_B  number of input-channel planes. Captured at `start`.
- `stall`  in  1  downstream back-pressure. When 1, no issue this cycle.
- `busy`  out  1  high from the cycle after an accepted `start` through the FLUSH cycle.
- `rd_en`  out  1  issue strobe; memory read request.
- `rd_addr`  out  9*ADDR_W  tap addresses. Tap k occupies `[ADDR_W*(k+1)-1 -: ADDR_W]`.
- `en_read`  out  9  tap valid mask, gated by `rd_en`.
- `en_bias`  out  1  high on issues with `ic_idx`==0, gated by `rd_en`.
- `ic_idx`  out  IC_B  current channel plane.
- `out_valid`  out  1  `rd_en` delayed one cycle. Aligns with the datapath's registered fmap.
- `out_last`  out  1  high with the final `out_valid` of a job.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Tap k maps to offset (dr,dc) = (k/3 − 1 counted from k=8, …). Bit 8 = (−1,−1), bit 7 = (−1,0), bit 6 = (−1,+1), …, bit 0 = (+1,+1). This is MSB-first row-major, matching fmap byte order.
- Tap k is valid iff 0 ≤ r+dr < cfg_h and 0 ≤ c+dc < cfg_w.
- Valid tap address = plane_base + (r+dr)*cfg_w + (c+dc), modulo 2^ADDR_W. Invalid tap address = 0.
- `plane_size` = cfg_w*cfg_h is registered at start. `plane_base` accumulates `plane_size` on each channel increment; no per-issue multiply. The row base is likewise accumulated by adding cfg_w.
- Loop order: ic outer, row, column inner.
- FSM states:
  - IDLE: on `start`, if any cfg field is 0, go to DONE; else load counters to 0 and go to RUN.
  - RUN: `rd_en` = !stall. Counters advance only on an issue. On the issue of (ic,r,c) = (cfg_ic−1, cfg_h−1, cfg_w−1), go to FLUSH.
  - FLUSH: one cycle; `out_valid`=`out_last`=`done`=1; go to IDLE.
  - DONE (zero-size jobs only): `done`=1 for one cycle, no `out_valid`; go to IDLE.
- Output timing: `rd_en`, `en_read`, `en_bias`, `rd_addr` and `ic_idx` are combinational from registered counters, state and `stall`. `out_valid` and `out_last` are registered.
- `stall` in FLUSH is ignored; the flush completes regardless.
- `start` while not in IDLE is ignored. cfg changes after `start` have no effect.
- Reset (async, any state): state=IDLE, counters=0, `plane_base`=0. Every output is 0, including `rd_addr`. An in-flight job is abandoned, and no `done` is produced for it.

## Timing
- `start` at cycle 0 → `busy` and first possible issue at cycle 1.
- With no stall: issues occupy cycles 1..N, N = cfg_w*cfg_h*cfg_ic. FLUSH with `done` at cycle N+1. IDLE at N+2, where a new `start` is accepted.
- Each stalled cycle adds exactly one cycle and yields `out_valid`=0 in the following cycle.
- Zero-size job: `done` at cycle 1, `busy` stays 0.

## Structure
- Package `npu_ctrl_pkg`:
  - FSM state enum (IDLE, RUN, FLUSH, DONE).
  - Tap offset constants TAP_DR[9] and TAP_DC[9].
  - Tap index localparams.
- Sub-module `window_tap_gen`: combinational. Takes r, c, cfg_w, cfg_h, row_base and plane_base; produces the 9-bit mask and the 9 addresses.
- Top level holds the FSM, counters, accumulators and output registers.

## Test plan
- 3x3 map, ic=1, no stall → 9 issues in cycles 1..9, `done` at cycle 10.
  - Pixel (0,0): `en_read`=9'b000_011_011; tap4 addr 0, tap3 addr 1, tap1 addr 3, tap0 addr 4.
  - Pixel (1,1): `en_read`=9'h1FF, addresses 0..8.
  - `en_bias`=1 on all issues.
- 4x2 map, ic=2 → 16 issues.
  - Plane 1 tap4 addresses are 8..15.
  - `en_bias`=0 and `ic_idx`=1 on issues 9..16.
  - `out_last` is high with the 16th `out_valid` only.
- 1x1 map: only tap4 is valid, `en_read`=9'b000_010_000. cfg_w=1 pads all left and right taps.
- `stall` high during cycles 3–5 of a 3x3 job:
  - `rd_en`=0 and `en_read`=0 in those cycles.
  - No pixel is skipped or repeated.
  - `done` at cycle 13.
- `start` with cfg_h=0 → `done` at cycle 1, no `rd_en`. `start` asserted while `busy` → ignored.
- `reset_n` low mid-job (at issue 5) → all outputs 0 immediately. After release, `start` runs a full job from pixel (0,0).
